io_output_driver: RTL and testbench

- Output-direction counterpart of the IO channel input conditioning; sits between the io channel control logic and the physical output pins (line1 optocoupler output, line2/line3 GPIO).
- Generates a delayed, width-programmable strobe pulse from the exposure trigger.
- Per line: selects the source (user level or strobe) and applies user polarity inversion.
- Pre-compensates circuit-level inversion so that each pin's logical level matches the programmed value.

---
 rtl/io_output_driver.sv | 138 +++++++++++++
 tb/tb_io_output_driver.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/io_output_driver.sv
// IO output driver: strobe pulse generation from the exposure trigger, per-line
// source select and polarity inversion, and pin-level drive for line1
// (optocoupler, inverted by the circuit) and line2/line3 (GPIO).

// Per-line source select and polarity: one instance per output line.
module io_line_sel (
    input  logic [1:0] source,
    input  logic       user,
    input  logic       strobe,
    input  logic       inv,
    output logic       level
);
    logic sel;

    // Source mux; codes 2 and 3 both force a logical low before inversion.
    always_comb begin
        sel = 1'b0;
        case (source)
            2'd0:    sel = user;
            2'd1:    sel = strobe;
            default: sel = 1'b0;
        endcase
        level = sel ^ inv;
    end
endmodule

module io_output_driver #(
    parameter int STROBE_CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_strobe_trig,
    input  logic [STROBE_CNT_WIDTH-1:0] iv_strobe_delay,
    input  logic [STROBE_CNT_WIDTH-1:0] iv_strobe_width,
    input  logic [5:0]                  iv_line_source,
    input  logic [2:0]                  iv_user_output,
    input  logic [2:0]                  iv_line_inverter,
    input  logic [1:0]                  iv_gpio_mode,
    output logic                        o_optocoupler_out,
    output logic [1:0]                  ov_gpio_out,
    output logic [1:0]                  ov_gpio_oe,
    output logic [2:0]                  ov_line_status,
    output logic                        o_strobe_busy
);
    localparam int NUM_LINES = 3;
    localparam logic [STROBE_CNT_WIDTH-1:0] CNT_ONE = STROBE_CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t                      state;
    logic [STROBE_CNT_WIDTH-1:0] delay_cnt;
    logic [STROBE_CNT_WIDTH-1:0] width_cnt;
    logic [STROBE_CNT_WIDTH-1:0] width_lat;
    logic                        strobe;
    logic [NUM_LINES-1:0]        logical;

    // Strobe sequencer. The strobe register trails the ACTIVE state by one clk,
    // so a trigger at edge N raises the strobe at edge N+1+D for W clocks.
    // Width is latched at trigger so mid-sequence register writes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            delay_cnt     <= '0;
            width_cnt     <= '0;
            width_lat     <= '0;
            strobe        <= 1'b0;
            o_strobe_busy <= 1'b0;
        end else begin
            strobe <= (state == ACTIVE);
            case (state)
                IDLE: begin
                    if (i_strobe_trig && (iv_strobe_width != '0)) begin
                        o_strobe_busy <= 1'b1;
                        width_lat     <= iv_strobe_width;
                        if (iv_strobe_delay == '0) begin
                            state     <= ACTIVE;
                            width_cnt <= iv_strobe_width - CNT_ONE;
                        end else begin
                            state     <= DELAY;
                            delay_cnt <= iv_strobe_delay - CNT_ONE;
                        end
                    end
                end
                DELAY: begin
                    if (delay_cnt == '0) begin
                        state     <= ACTIVE;
                        width_cnt <= width_lat - CNT_ONE;
                    end else begin
                        delay_cnt <= delay_cnt - CNT_ONE;
                    end
                end
                ACTIVE: begin
                    if (width_cnt == '0) begin
                        state         <= IDLE;
                        o_strobe_busy <= 1'b0;
                    end else begin
                        width_cnt <= width_cnt - CNT_ONE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    o_strobe_busy <= 1'b0;
                end
            endcase
        end
    end

    // One select/invert slice per line: line1 = bit 0, line2 = bit 1, line3 = bit 2.
    for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
        io_line_sel u_sel (
            .source (iv_line_source[2*i +: 2]),
            .user   (iv_user_output[i]),
            .strobe (strobe),
            .inv    (iv_line_inverter[i]),
            .level  (logical[i])
        );
    end

    // Pin register stage. Line1 is pre-inverted because the optocoupler stage
    // inverts again; GPIO data follows the logical level even in input mode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_optocoupler_out <= 1'b1;
            ov_gpio_out       <= 2'b00;
            ov_gpio_oe        <= 2'b00;
            ov_line_status    <= 3'b000;
        end else begin
            o_optocoupler_out <= ~logical[0];
            ov_gpio_out       <= logical[2:1];
            ov_gpio_oe        <= iv_gpio_mode;
            ov_line_status    <= logical;
        end
    end
endmodule

// File: tb/tb_io_output_driver.sv
// Directed bench for io_output_driver: reset values, strobe timing, zero
// delay/width, retrigger and width latching, source/inverter muxing, and
// reset in the middle of a pulse.
module tb_io_output_driver;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          trig;
    logic [CW-1:0] delay;
    logic [CW-1:0] width;
    logic [5:0]    line_source;
    logic [2:0]    user_output;
    logic [2:0]    line_inverter;
    logic [1:0]    gpio_mode;
    logic          opto;
    logic [1:0]    gpio_out;
    logic [1:0]    gpio_oe;
    logic [2:0]    line_status;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    io_output_driver #(.STROBE_CNT_WIDTH(CW)) dut (
        .clk               (clk),
        .reset             (reset),
        .i_strobe_trig     (trig),
        .iv_strobe_delay   (delay),
        .iv_strobe_width   (width),
        .iv_line_source    (line_source),
        .iv_user_output    (user_output),
        .iv_line_inverter  (line_inverter),
        .iv_gpio_mode      (gpio_mode),
        .o_optocoupler_out (opto),
        .ov_gpio_out       (gpio_out),
        .ov_gpio_oe        (gpio_oe),
        .ov_line_status    (line_status),
        .o_strobe_busy     (busy)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int lows;
        int first;

        reset = 1'b1; trig = 1'b0; delay = '0; width = '0;
        line_source = 6'b00_00_01; user_output = 3'b000;
        line_inverter = 3'b000; gpio_mode = 2'b00;

        // Reset values
        tick(); tick();
        check("rst_opto",   32'(opto), 32'd1);
        check("rst_gpio",   32'(gpio_out), 32'd0);
        check("rst_oe",     32'(gpio_oe), 32'd0);
        check("rst_status", 32'(line_status), 32'd0);
        check("rst_busy",   32'(busy), 32'd0);
        reset = 1'b0;
        tick(); tick();

        // Basic strobe: D=3, W=5 -> pin low after edges N+5..N+9
        delay = 16'd3; width = 16'd5;
        trig = 1'b1; tick(); trig = 1'b0;
        check("basic_busy0", 32'(busy), 32'd1);
        for (int k = 1; k <= 11; k++) begin
            tick();
            check($sformatf("basic_opto_k%0d", k), 32'(opto), (k >= 5 && k <= 9) ? 32'd0 : 32'd1);
            check($sformatf("basic_stat_k%0d", k), 32'(line_status[0]), (k >= 5 && k <= 9) ? 32'd1 : 32'd0);
            if (k <= 7) check($sformatf("basic_busy_k%0d", k), 32'(busy), 32'd1);
            if (k == 11) check("basic_busy_end", 32'(busy), 32'd0);
        end

        // Zero delay: D=0, W=2 -> pin low after edges N+2..N+3
        delay = 16'd0; width = 16'd2;
        trig = 1'b1; tick(); trig = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("d0_opto_k%0d", k), 32'(opto), (k == 2 || k == 3) ? 32'd0 : 32'd1);
        end

        // Zero width: no pulse, busy never rises
        delay = 16'd3; width = 16'd0;
        trig = 1'b1; tick(); trig = 1'b0;
        check("w0_busy0", 32'(busy), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("w0_busy_k%0d", k), 32'(busy), 32'd0);
            check($sformatf("w0_opto_k%0d", k), 32'(opto), 32'd1);
        end

        // Retrigger in DELAY ignored; width change mid-pulse ignored
        delay = 16'd3; width = 16'd4;
        trig = 1'b1; tick();
        tick(); trig = 1'b0;
        lows = 0; first = -1;
        for (int k = 2; k <= 20; k++) begin
            if (k == 6) width = 16'd10;
            tick();
            if (opto === 1'b0) begin
                lows++;
                if (first < 0) first = k;
            end
        end
        check("retrig_len",   32'(lows), 32'd4);
        check("retrig_first", 32'(first), 32'd5);
        check("retrig_busy",  32'(busy), 32'd0);

        // Source / inverter: line2 user=1 inverted, gpio output mode
        line_source = 6'b00_00_00; user_output = 3'b010;
        line_inverter = 3'b010; gpio_mode = 2'b01;
        tick();
        check("src_gpio0",  32'(gpio_out[0]), 32'd0);
        check("src_oe0",    32'(gpio_oe[0]), 32'd1);
        check("src_stat1",  32'(line_status[1]), 32'd0);
        check("src_opto",   32'(opto), 32'd1);
        // line2 forced low, inverter still on -> high
        line_source = 6'b00_10_00;
        tick();
        check("low_gpio0",  32'(gpio_out[0]), 32'd1);
        check("low_stat1",  32'(line_status[1]), 32'd1);
        // line3 user high in input mode; line1 inverted
        user_output = 3'b110; line_inverter = 3'b011;
        tick();
        check("mix_gpio",   32'(gpio_out), 32'd3);
        check("mix_oe",     32'(gpio_oe), 32'd1);
        check("mix_status", 32'(line_status), 32'd7);
        check("mix_opto",   32'(opto), 32'd0);

        // Reset mid-ACTIVE, then a trigger right after release
        line_source = 6'b00_00_01; user_output = 3'b000;
        line_inverter = 3'b000; gpio_mode = 2'b11;
        delay = 16'd0; width = 16'd100;
        trig = 1'b1; tick(); trig = 1'b0;
        for (int k = 1; k <= 11; k++) tick();
        check("mid_opto_pre", 32'(opto), 32'd0);
        check("mid_oe_pre",   32'(gpio_oe), 32'd3);
        reset = 1'b1;
        #1;
        check("mid_rst_opto",   32'(opto), 32'd1);
        check("mid_rst_gpio",   32'(gpio_out), 32'd0);
        check("mid_rst_oe",     32'(gpio_oe), 32'd0);
        check("mid_rst_status", 32'(line_status), 32'd0);
        check("mid_rst_busy",   32'(busy), 32'd0);
        tick();
        reset = 1'b0;
        trig = 1'b1; tick(); trig = 1'b0;
        check("post_busy", 32'(busy), 32'd1);
        lows = 0; first = -1;
        for (int k = 1; k <= 150; k++) begin
            tick();
            if (opto === 1'b0) begin
                lows++;
                if (first < 0) first = k;
            end
        end
        check("post_len",      32'(lows), 32'd100);
        check("post_first",    32'(first), 32'd2);
        check("post_busy_end", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
